// File: rtl/core_pkg.sv
// Shared core types: RV32 major opcodes, AMO funct5 codes and decode-queue types.
package core_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_AMO      = 7'h2F,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } opcode_e;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_e;

    typedef enum logic [1:0] {
        DQ_NORMAL,
        DQ_AMO_P1,
        DQ_SER_WAIT
    } decq_state_e;

    typedef struct packed {
        logic amo_rmw;
        logic serial;
        logic illegal_opcode;
    } predec_t;

endpackage

// File: rtl/core_predecode.sv
// Combinational instruction-class predecode for the decode queue.
module core_predecode
    import core_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        fault,
    output predec_t     pd
);

    logic opc_known;
    logic rmw_funct5;
    logic is_amo;
    logic is_serial;
    logic unused_bits;

    assign unused_bits = ^instr[26:7];

    always_comb begin
        opc_known = 1'b0;
        case (instr[6:0])
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_AMO, OPC_SYSTEM,
            OPC_MISC_MEM: opc_known = 1'b1;
            default:      opc_known = 1'b0;
        endcase
    end

    // LR/SC are single-phase; only the read-modify-write family needs a write phase.
    always_comb begin
        rmw_funct5 = 1'b0;
        case (instr[31:27])
            AMO_SWAP, AMO_ADD, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: rmw_funct5 = 1'b1;
            default:                              rmw_funct5 = 1'b0;
        endcase
    end

    assign is_amo    = (instr[6:0] == OPC_AMO);
    assign is_serial = (instr[6:0] == OPC_SYSTEM) || (instr[6:0] == OPC_MISC_MEM);

    always_comb begin
        pd                = '0;
        pd.amo_rmw        = ~fault & is_amo & rmw_funct5;
        pd.serial         = ~fault & is_serial;
        pd.illegal_opcode = (instr[1:0] != 2'b11) | ~opc_known;
    end

endmodule

// File: rtl/core_decode_queue.sv
// Fetch-to-decode instruction queue with AMO two-phase issue and serialization stall.
// Optional fetch-to-decode bypass when empty: define CORE_DECQ_BYPASS_EN.
module core_decode_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [31:0]                fetch_instr,
    input  logic [XLEN-1:0]            fetch_pc,
    input  logic                       fetch_fault,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [31:0]                dec_instr,
    output logic [XLEN-1:0]            dec_pc,
    output logic                       dec_fault,
    output logic                       dec_illegal_opcode,
    output logic                       dec_exec_phase,
    output logic                       dec_serialize,
    input  logic                       serial_done,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]     mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic            mem_fault [DEPTH];
    predec_t         mem_pd    [DEPTH];

    decq_state_e     state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    predec_t          push_pd;
    logic             bypass_active;
    logic             head_valid;
    logic [31:0]      head_instr;
    logic [XLEN-1:0]  head_pc;
    logic             head_fault;
    predec_t          head_pd;
    logic             hs;
    logic             bypass_consume;
    logic             push;
    logic             wr_en;
    logic             rd_en;

    core_predecode u_predecode (
        .instr (fetch_instr),
        .fault (fetch_fault),
        .pd    (push_pd)
    );

`ifdef CORE_DECQ_BYPASS_EN
    assign bypass_active = ~rst & ~flush & (count_q == '0) & (state == DQ_NORMAL);
`else
    assign bypass_active = 1'b0;
`endif

    always_comb begin
        head_valid = (count_q != '0) && (state != DQ_SER_WAIT);
        head_instr = mem_instr[rd_ptr];
        head_pc    = mem_pc[rd_ptr];
        head_fault = mem_fault[rd_ptr];
        head_pd    = mem_pd[rd_ptr];
`ifdef CORE_DECQ_BYPASS_EN
        if (bypass_active) begin
            head_valid = fetch_valid;
            head_instr = fetch_instr;
            head_pc    = fetch_pc;
            head_fault = fetch_fault;
            head_pd    = push_pd;
        end
`endif
    end

    assign hs   = head_valid & dec_ready;
    assign push = fetch_valid & fetch_ready & ~flush;

    // A bypassed plain instruction is consumed straight from fetch; AMO/serial
    // ones are still written so the state machine can track them from storage.
    assign bypass_consume = bypass_active & hs & ~head_pd.amo_rmw & ~head_pd.serial;
    assign wr_en = push & ~bypass_consume;
    assign rd_en = hs & ~bypass_consume &
                   (((state == DQ_NORMAL) & ~head_pd.amo_rmw) | (state == DQ_AMO_P1));

    assign fetch_ready        = ~rst & (count_q < CNT_W'(DEPTH));
    assign count              = count_q;
    assign dec_valid          = head_valid;
    assign dec_instr          = head_valid ? head_instr : '0;
    assign dec_pc             = head_valid ? head_pc    : '0;
    assign dec_fault          = head_valid & head_fault;
    assign dec_illegal_opcode = head_valid & head_pd.illegal_opcode;
    assign dec_serialize      = head_valid & head_pd.serial;
    assign dec_exec_phase     = head_valid & (state == DQ_AMO_P1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr[wr_ptr] <= fetch_instr;
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_fault[wr_ptr] <= fetch_fault;
            mem_pd[wr_ptr]    <= push_pd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state   <= DQ_NORMAL;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            case (state)
                DQ_NORMAL: begin
                    if (hs && head_pd.amo_rmw)
                        state <= DQ_AMO_P1;
                    else if (hs && head_pd.serial)
                        state <= DQ_SER_WAIT;
                end
                DQ_AMO_P1: begin
                    if (hs)
                        state <= DQ_NORMAL;
                end
                DQ_SER_WAIT: begin
                    if (serial_done)
                        state <= DQ_NORMAL;
                end
                default: state <= DQ_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_core_decode_queue.sv
// Directed self-checking bench for core_decode_queue (default build, no bypass).
module tb_core_decode_queue;

    localparam logic [31:0] I_ADDI    = 32'h00100093;
    localparam logic [31:0] I_AMOADD  = 32'h00A5A52F;
    localparam logic [31:0] I_LRW     = 32'h1005A52F;
    localparam logic [31:0] I_AMOSWAP = 32'h08A5A52F;
    localparam logic [31:0] I_CSRRW   = 32'h34011073;
    localparam logic [31:0] I_ADD     = 32'h003100B3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_fault;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_fault;
    logic        dec_illegal_opcode;
    logic        dec_exec_phase;
    logic        dec_serialize;
    logic        serial_done;
    logic [2:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    core_decode_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .fetch_valid        (fetch_valid),
        .fetch_ready        (fetch_ready),
        .fetch_instr        (fetch_instr),
        .fetch_pc           (fetch_pc),
        .fetch_fault        (fetch_fault),
        .dec_valid          (dec_valid),
        .dec_ready          (dec_ready),
        .dec_instr          (dec_instr),
        .dec_pc             (dec_pc),
        .dec_fault          (dec_fault),
        .dec_illegal_opcode (dec_illegal_opcode),
        .dec_exec_phase     (dec_exec_phase),
        .dec_serialize      (dec_serialize),
        .serial_done        (serial_done),
        .count              (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc, input logic fault);
        fetch_valid = 1'b1;
        fetch_instr = instr;
        fetch_pc    = pc;
        fetch_fault = fault;
        step();
        fetch_valid = 1'b0;
        fetch_instr = '0;
        fetch_pc    = '0;
        fetch_fault = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0;
        fetch_pc = '0; fetch_fault = 1'b0; dec_ready = 1'b0; serial_done = 1'b0;

        // Reset state
        step();
        check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_fetch_ready", 64'(fetch_ready), 64'd1);
        check("post_rst_dec_valid", 64'(dec_valid), 64'd0);
        check("post_rst_dec_instr", 64'(dec_instr), 64'd0);

        // Single ADDI, one-cycle latency
        dec_ready = 1'b1;
        push_one(I_ADDI, 32'h100, 1'b0);
        check("addi_valid", 64'(dec_valid), 64'd1);
        check("addi_pc", 64'(dec_pc), 64'h100);
        check("addi_instr", 64'(dec_instr), 64'(I_ADDI));
        check("addi_illegal", 64'(dec_illegal_opcode), 64'd0);
        check("addi_count", 64'(count), 64'd1);
        step();
        check("addi_count_after", 64'(count), 64'd0);
        check("addi_valid_after", 64'(dec_valid), 64'd0);

        // Fill to full, fifth push refused, then drain across the pointer wrap
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = 32'h00000093 | (32'(i) << 20);
            fetch_pc    = 32'h200 + 32'(4 * i);
            check($sformatf("fill_ready_%0d", i), 64'(fetch_ready), (i < 4) ? 64'd1 : 64'd0);
            step();
        end
        fetch_valid = 1'b0;
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(fetch_ready), 64'd0);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid_%0d", i), 64'(dec_valid), 64'd1);
            check($sformatf("drain_pc_%0d", i), 64'(dec_pc), 64'(32'h200 + 32'(4 * i)));
            check($sformatf("drain_instr_%0d", i), 64'(dec_instr),
                  64'(32'h00000093 | (32'(i) << 20)));
            step();
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_valid_end", 64'(dec_valid), 64'd0);

        // AMOADD.W: two handshakes, phase 0 then 1, single pop
        push_one(I_AMOADD, 32'h300, 1'b0);
        check("amo_p0_valid", 64'(dec_valid), 64'd1);
        check("amo_p0_phase", 64'(dec_exec_phase), 64'd0);
        check("amo_p0_pc", 64'(dec_pc), 64'h300);
        step();
        check("amo_p1_valid", 64'(dec_valid), 64'd1);
        check("amo_p1_phase", 64'(dec_exec_phase), 64'd1);
        check("amo_p1_pc", 64'(dec_pc), 64'h300);
        check("amo_p1_count", 64'(count), 64'd1);
        step();
        check("amo_done_count", 64'(count), 64'd0);
        check("amo_done_valid", 64'(dec_valid), 64'd0);

        // LR.W is single-phase
        push_one(I_LRW, 32'h304, 1'b0);
        check("lr_phase", 64'(dec_exec_phase), 64'd0);
        check("lr_valid", 64'(dec_valid), 64'd1);
        step();
        check("lr_count", 64'(count), 64'd0);
        check("lr_valid_after", 64'(dec_valid), 64'd0);

        // CSRRW then ADD: stall until serial_done
        dec_ready = 1'b0;
        push_one(I_CSRRW, 32'h400, 1'b0);
        push_one(I_ADD, 32'h404, 1'b0);
        check("ser_count", 64'(count), 64'd2);
        check("ser_flag", 64'(dec_serialize), 64'd1);
        check("ser_pc", 64'(dec_pc), 64'h400);
        dec_ready = 1'b1;
        step();
        check("ser_wait1_valid", 64'(dec_valid), 64'd0);
        check("ser_wait1_count", 64'(count), 64'd1);
        step();
        check("ser_wait2_valid", 64'(dec_valid), 64'd0);
        step();
        serial_done = 1'b1;
        check("ser_wait3_valid", 64'(dec_valid), 64'd0);
        step();
        serial_done = 1'b0;
        check("ser_resume_valid", 64'(dec_valid), 64'd1);
        check("ser_resume_pc", 64'(dec_pc), 64'h404);
        check("ser_resume_flag", 64'(dec_serialize), 64'd0);
        step();
        check("ser_end_count", 64'(count), 64'd0);

        // Flush with 3 entries in DQ_AMO_P1, colliding with push/pop/serial_done
        dec_ready = 1'b0;
        push_one(I_AMOADD, 32'h500, 1'b0);
        push_one(I_ADDI, 32'h504, 1'b0);
        push_one(I_ADDI, 32'h508, 1'b0);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("pre_flush_phase", 64'(dec_exec_phase), 64'd1);
        check("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1; fetch_valid = 1'b1; fetch_instr = I_ADDI; fetch_pc = 32'h50C;
        dec_ready = 1'b1; serial_done = 1'b1;
        step();
        flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0; serial_done = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(dec_valid), 64'd0);
        check("flush_ready", 64'(fetch_ready), 64'd1);
        push_one(I_ADDI, 32'h600, 1'b0);
        check("post_flush_valid", 64'(dec_valid), 64'd1);
        check("post_flush_phase", 64'(dec_exec_phase), 64'd0);
        check("post_flush_pc", 64'(dec_pc), 64'h600);
        dec_ready = 1'b1;
        step();
        check("post_flush_count", 64'(count), 64'd0);

        // Illegal all-zero word, and faulted AMOSWAP single handshake
        push_one(32'h0, 32'h700, 1'b0);
        check("illegal_flag", 64'(dec_illegal_opcode), 64'd1);
        check("illegal_valid", 64'(dec_valid), 64'd1);
        step();
        push_one(I_AMOSWAP, 32'h704, 1'b1);
        check("fault_flag", 64'(dec_fault), 64'd1);
        check("fault_phase", 64'(dec_exec_phase), 64'd0);
        check("fault_serialize", 64'(dec_serialize), 64'd0);
        step();
        check("fault_count", 64'(count), 64'd0);
        check("fault_valid_after", 64'(dec_valid), 64'd0);

        // Reset mid-operation clears everything
        dec_ready = 1'b0;
        push_one(I_ADDI, 32'h800, 1'b0);
        push_one(I_ADD, 32'h804, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_valid", 64'(dec_valid), 64'd0);
        check("midrst_ready", 64'(fetch_ready), 64'd0);
        rst = 1'b0;
        step();
        check("midrst_ready_after", 64'(fetch_ready), 64'd1);
        check("midrst_count_after", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_decode_queue.md
# core_decode_queue

Parametrised instruction buffer between fetch and the core decoder/exec stage. It stores fetched instructions with a predecoded class, presents the head entry with a valid/ready handshake, and generates the exec phase for two-phase AMO read-modify-write instructions. It also stalls issue behind serializing instructions until exec reports completion, and supports pipeline flush.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2
- `XLEN`, 32, PC width

- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `flush`  in  1  discard all entries and return to `DQ_NORMAL`
- `fetch_valid`  in  1  fetch offers an instruction
- `fetch_ready`  out  1  queue accepts
- `fetch_instr`  in  32  instruction word
- `fetch_pc`  in  XLEN  instruction PC
- `fetch_fault`  in  1  fetch access/page fault for this PC
- `dec_valid`  out  1  head entry presented
- `dec_ready`  in  1  exec consumes the presented phase
- `dec_instr`  out  32  head instruction
- `dec_pc`  out  XLEN  head PC
- `dec_fault`  out  1  head fetch fault
- `dec_illegal_opcode`  out  1  predecoded illegal major opcode
- `dec_exec_phase`  out  1  0 = first or only phase; 1 = AMO write phase
- `dec_serialize`  out  1  head is SYSTEM or MISC-MEM
- `serial_done`  in  1  pulse: serializing instruction completed in exec
- `count`  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push: `fetch_valid & fetch_ready & ~flush`. Entry stores instr, pc, fault, and a predecode computed at push time.
  - `amo_rmw`: opcode AMO, funct5 ∈ {SWAP, ADD, XOR, OR, AND, MIN, MAX, MINU, MAXU}, no fault.
  - `serial`: opcode SYSTEM or MISC-MEM, no fault.
  - `illegal_opcode`: `instr[1:0]≠2'b11`, or opcode outside {OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, AMO, SYSTEM, MISCMEM}.
- `fetch_ready = ~rst & (count < DEPTH)`. There is no push-through when full.
- State machine (`decq_state_e`):
  - **DQ_NORMAL**:
    - handshake on `amo_rmw` head → `DQ_AMO_P1`, entry retained;
    - handshake on `serial` head → pop, go to `DQ_SER_WAIT`;
    - handshake on any other head → pop, stay.
  - **DQ_AMO_P1**: same head presented with `dec_exec_phase=1`. Handshake → pop, `DQ_NORMAL`.
  - **DQ_SER_WAIT**: `dec_valid=0`; pushes still accepted. `serial_done` → `DQ_NORMAL`.
- `dec_valid = (count≠0) & (state≠DQ_SER_WAIT)`. All `dec_*` payload outputs are 0 while `dec_valid=0`.
- Faulted entries always pop in a single handshake. `dec_serialize=0` and `dec_exec_phase=0` for them.
- Flush: count, pointers and state are cleared next cycle. Flush beats a simultaneous push, pop and `serial_done`.
- Simultaneous push and pop: count is unchanged; both pointers advance modulo DEPTH (natural wrap).
- `serial_done` outside `DQ_SER_WAIT` is ignored.

## Timing
- Reset, and the cycle after: `count=0`, state `DQ_NORMAL`, `dec_valid=0`, payload 0. `fetch_ready=0` during reset and 1 from the first cycle after.
- Push to `dec_valid`: 1 cycle when the queue is empty (0 with bypass).
- An AMO RMW occupies 2 handshakes; back-to-back handshakes sustain 1 pop per 2 cycles.
- Serializing instruction: `dec_valid` is low from the cycle after its handshake through the cycle `serial_done` is sampled. It is high again the next cycle if `count≠0`.
- Reset mid-operation: all state is lost, identical to flush.

## Configuration
- Macro: `CORE_DECQ_BYPASS_EN`.
- Defined: when `count=0`, state is `DQ_NORMAL` and `flush=0`, the fetch input drives `dec_*` combinationally with `dec_valid=fetch_valid`, using live predecode.
  - If the handshake completes and the instruction is neither `amo_rmw` nor `serial`, nothing is written.
  - Otherwise the instruction is written normally and the state transition applies.
- Undefined: `dec_*` is driven only from storage; minimum latency is 1 cycle.

## Structure
- `core_pkg` additions:
  - `decq_state_e` {`DQ_NORMAL`, `DQ_AMO_P1`, `DQ_SER_WAIT`};
  - packed struct `predec_t` {`amo_rmw`, `serial`, `illegal_opcode`}.
- Reuses the existing `opcode_e` and `amo_op_e`.
- Sub-module `core_predecode`: combinational, `instr` + `fault` → `predec_t`. Used at the push port and on the bypass path.

## Test plan
- Push ADDI (`0x00100093`), PC `0x100`, into an empty queue, `dec_ready=1` → `dec_valid` the next cycle (same cycle with bypass), `dec_pc=0x100`, `count` returns to 0.
- Push 5 instructions with `DEPTH=4`, `dec_ready=0` → `fetch_ready=0` after 4, `count=4`. Drain → values in order, pointers wrap.
- Push AMOADD.W (`0x00A5A52F`) → two handshakes with `dec_exec_phase` 0 then 1, same PC; a single pop. LR.W → one handshake, phase 0.
- Push CSRRW followed by ADD → CSRRW handshake, `dec_valid=0` for 3 cycles until `serial_done`, then ADD presented.
- Assert `flush` in the same cycle as a push, with 3 entries held and state `DQ_AMO_P1` → next cycle `count=0`, `dec_valid=0`, state `DQ_NORMAL`.
- `fetch_instr=0x00000000` → `dec_illegal_opcode=1`. `fetch_fault=1` on AMOSWAP → single handshake, `dec_fault=1`, phase 0.
